btb_update_queue: RTL and testbench

//  Buffers branch-training updates resolved in the EX02 writeback stage until
//  the BTB's single write port is free; fetch lookups own that port first.
//  EX02 cannot stall, so the queue never back-pressures. It drops on overflow,

---
 rtl/biriq_bpu_pkg.sv | 28 ++
 rtl/btb_update_queue.sv | 119 +++++++++++
 tb/tb_btb_update_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/biriq_bpu_pkg.sv
// Shared branch-prediction types: BTB training record and 2-bit counter helpers.
package biriq_bpu_pkg;

   localparam logic [1:0] CNTR_WEAK_T  = 2'b10;
   localparam logic [1:0] CNTR_WEAK_NT = 2'b01;

   // One BTB training update; 70 bits. The branch type field is named btype
   // because "type" is a reserved word.
   typedef struct packed {
      logic [29:0] vpc;
      logic [29:0] target;
      logic [1:0]  cntr;
      logic        tkn;
      logic [1:0]  btype;
      logic        present;
      logic        way;
      logic        bm_mod;
      logic        call;
      logic        ret;
   } btb_upd_t;

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic logic [1:0] sat_cntr2(input logic [1:0] cntr, input logic tkn);
      if (tkn) return (cntr == 2'b11) ? 2'b11 : cntr + 2'b01;
      else     return (cntr == 2'b00) ? 2'b00 : cntr - 2'b01;
   endfunction

endpackage

// File: rtl/btb_update_queue.sv
// Non-stalling FIFO of BTB training updates: merges same-slot tail updates,
// drops on overflow, and stores the already-updated 2-bit counter.
module btb_update_queue
   import biriq_bpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        core_clock_i,
   input  logic        core_reset_i,
   input  logic        upd_valid_i,
   input  logic [29:0] upd_vpc_i,
   input  logic [29:0] upd_target_i,
   input  logic [1:0]  upd_cntr_i,
   input  logic        upd_tkn_i,
   input  logic [1:0]  upd_type_i,
   input  logic        upd_present_i,
   input  logic        upd_way_i,
   input  logic        upd_bm_mod_i,
   input  logic        upd_call_i,
   input  logic        upd_ret_i,
   input  logic        btb_ready_i,
   output logic        btb_valid_o,
   output logic [29:0] btb_vpc_o,
   output logic [29:0] btb_target_o,
   output logic [1:0]  btb_cntr_o,
   output logic        btb_tkn_o,
   output logic [1:0]  btb_type_o,
   output logic        btb_present_o,
   output logic        btb_way_o,
   output logic        btb_bm_mod_o,
   output logic        btb_call_o,
   output logic        btb_ret_o,
   output logic        drop_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   btb_upd_t         q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [PTR_W:0]   count;
   logic             pop;
   logic             merge;
   logic             push;
   btb_upd_t         wdata;
   btb_upd_t         head;

   // Decide pop/merge/push/drop and build the entry to write.
   always_comb begin
      tail_ptr = wr_ptr - PTR_W'(1);
      pop      = (count != '0) && btb_ready_i;
      // When count==1 the tail is the head; a merge into an entry leaving
      // this cycle would be lost, so it enqueues fresh instead.
      merge    = upd_valid_i && (count != '0)
                 && (q[tail_ptr].vpc == upd_vpc_i)
                 && (q[tail_ptr].way == upd_way_i)
                 && !(pop && (count == (PTR_W+1)'(1)));
      push     = upd_valid_i && !merge && ((count < (PTR_W+1)'(DEPTH)) || pop);
      drop_o   = upd_valid_i && !merge && !push;

      wdata.vpc     = upd_vpc_i;
      wdata.target  = upd_target_i;
      wdata.tkn     = upd_tkn_i;
      wdata.btype   = upd_type_i;
      wdata.present = upd_present_i;
      wdata.way     = upd_way_i;
      wdata.bm_mod  = upd_bm_mod_i;
      wdata.call    = upd_call_i;
      wdata.ret     = upd_ret_i;
      if (!upd_present_i)
         wdata.cntr = upd_tkn_i ? CNTR_WEAK_T : CNTR_WEAK_NT;
      else
         wdata.cntr = sat_cntr2(upd_cntr_i, upd_tkn_i);
      if (merge) begin
         wdata.cntr   = sat_cntr2(q[tail_ptr].cntr, upd_tkn_i);
         wdata.bm_mod = upd_bm_mod_i | q[tail_ptr].bm_mod;
         wdata.call   = upd_call_i   | q[tail_ptr].call;
         wdata.ret    = upd_ret_i    | q[tail_ptr].ret;
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (pop && !push) count <= count - (PTR_W+1)'(1);
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge core_clock_i) begin
      if (merge)     q[tail_ptr] <= wdata;
      else if (push) q[wr_ptr]   <= wdata;
   end

   // Head entry drives the BTB write port.
   always_comb begin
      head          = q[rd_ptr];
      btb_valid_o   = (count != '0);
      btb_vpc_o     = head.vpc;
      btb_target_o  = head.target;
      btb_cntr_o    = head.cntr;
      btb_tkn_o     = head.tkn;
      btb_type_o    = head.btype;
      btb_present_o = head.present;
      btb_way_o     = head.way;
      btb_bm_mod_o  = head.bm_mod;
      btb_call_o    = head.call;
      btb_ret_o     = head.ret;
   end

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: a queue model of expected entries,
// stimulus mutates it, a negedge monitor compares the presented head.
module tb_btb_update_queue;
   import biriq_bpu_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        upd_valid;
   logic [29:0] upd_vpc, upd_target;
   logic [1:0]  upd_cntr, upd_type;
   logic        upd_tkn, upd_present, upd_way, upd_bm_mod, upd_call, upd_ret;
   logic        btb_ready;
   logic        btb_valid;
   logic [29:0] btb_vpc, btb_target;
   logic [1:0]  btb_cntr, btb_type;
   logic        btb_tkn, btb_present, btb_way, btb_bm_mod, btb_call, btb_ret;
   logic        drop;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   btb_upd_t    exp_q[$];
   btb_upd_t    obs;

   always #5 clk = ~clk;

   btb_update_queue #(.DEPTH(DEPTH)) dut (
      .core_clock_i(clk), .core_reset_i(rst),
      .upd_valid_i(upd_valid), .upd_vpc_i(upd_vpc), .upd_target_i(upd_target),
      .upd_cntr_i(upd_cntr), .upd_tkn_i(upd_tkn), .upd_type_i(upd_type),
      .upd_present_i(upd_present), .upd_way_i(upd_way), .upd_bm_mod_i(upd_bm_mod),
      .upd_call_i(upd_call), .upd_ret_i(upd_ret), .btb_ready_i(btb_ready),
      .btb_valid_o(btb_valid), .btb_vpc_o(btb_vpc), .btb_target_o(btb_target),
      .btb_cntr_o(btb_cntr), .btb_tkn_o(btb_tkn), .btb_type_o(btb_type),
      .btb_present_o(btb_present), .btb_way_o(btb_way), .btb_bm_mod_o(btb_bm_mod),
      .btb_call_o(btb_call), .btb_ret_o(btb_ret), .drop_o(drop)
   );

   assign obs = '{vpc: btb_vpc, target: btb_target, cntr: btb_cntr, tkn: btb_tkn,
                  btype: btb_type, present: btb_present, way: btb_way,
                  bm_mod: btb_bm_mod, call: btb_call, ret: btb_ret};

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Counter rule in plain integer arithmetic, clamped to 0..3.
   function automatic logic [1:0] ref_cntr(input int base, input logic tkn, input logic miss);
      int n;
      if (miss) return tkn ? 2'd2 : 2'd1;
      n = tkn ? base + 1 : base - 1;
      if (n > 3) n = 3;
      if (n < 0) n = 0;
      return 2'(n);
   endfunction

   function automatic btb_upd_t mk(input logic [29:0] vpc, input logic way,
                                   input logic [1:0] cntr, input logic tkn, input logic present);
      btb_upd_t u;
      u.vpc = vpc; u.way = way; u.cntr = cntr; u.tkn = tkn; u.present = present;
      u.target = 30'($urandom); u.btype = 2'($urandom);
      u.bm_mod = 1'($urandom); u.call = 1'($urandom); u.ret = 1'($urandom);
      return u;
   endfunction

   // Expected effect of one clock edge on the model queue, plus drop check.
   task automatic model_step(input logic v, input btb_upd_t u, input logic rdy);
      int       sz;
      bit       pop;
      bit       d;
      btb_upd_t e;
      btb_upd_t t;
      sz  = exp_q.size();
      pop = (sz != 0) && rdy;
      d   = 1'b0;
      if (v) begin
         if (sz > 0) t = exp_q[sz-1];
         if (sz > 0 && t.vpc == u.vpc && t.way == u.way && !(pop && sz == 1)) begin
            e = u;
            e.cntr   = ref_cntr(int'(t.cntr), u.tkn, 1'b0);
            e.bm_mod = u.bm_mod | t.bm_mod;
            e.call   = u.call | t.call;
            e.ret    = u.ret | t.ret;
            exp_q[sz-1] = e;
         end else if (sz < DEPTH || pop) begin
            e = u;
            e.cntr = ref_cntr(int'(u.cntr), u.tkn, !u.present);
            exp_q.push_back(e);
         end else begin
            d = 1'b1;
         end
      end
      chk("drop", 70'(drop), 70'(d));
      if (pop) void'(exp_q.pop_front());
   endtask

   // One clock cycle of stimulus; the model advances after the monitor has looked.
   task automatic cycle(input logic v, input btb_upd_t u, input logic rdy);
      @(posedge clk);
      #1;
      upd_valid = v; upd_vpc = u.vpc; upd_target = u.target; upd_cntr = u.cntr;
      upd_tkn = u.tkn; upd_type = u.btype; upd_present = u.present; upd_way = u.way;
      upd_bm_mod = u.bm_mod; upd_call = u.call; upd_ret = u.ret; btb_ready = rdy;
      @(negedge clk);
      #1;
      model_step(v, u, rdy);
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, mk(30'h0, 1'b0, 2'd0, 1'b0, 1'b0), rdy);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH + 2; i++) idle(1'b1);
   endtask

   // Asynchronous reset asserted mid-cycle; valid must drop immediately.
   task automatic do_reset();
      @(posedge clk);
      #2;
      upd_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("reset_valid_async", 70'(btb_valid), 70'(0));
      chk("reset_drop", 70'(drop), 70'(0));
      exp_q.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compare presented head against the model front every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("valid", 70'(btb_valid), 70'(exp_q.size() != 0));
            if (btb_valid && exp_q.size() != 0) chk("head", obs, exp_q[0]);
         end
      end
   end

   initial begin
      rst = 1'b1;
      upd_valid = 1'b0; upd_vpc = '0; upd_target = '0; upd_cntr = '0; upd_tkn = 1'b0;
      upd_type = '0; upd_present = 1'b0; upd_way = 1'b0; upd_bm_mod = 1'b0;
      upd_call = 1'b0; upd_ret = 1'b0; btb_ready = 1'b0;
      #12;
      chk("init_valid", 70'(btb_valid), 70'(0));
      chk("init_drop", 70'(drop), 70'(0));
      @(negedge clk);
      #1;
      rst = 1'b0;

      // Reset in the middle of traffic with three entries queued.
      for (int i = 0; i < 3; i++) cycle(1'b1, mk(30'h40 + 30'(i), 1'b0, 2'd1, 1'b1, 1'b1), 1'b0);
      do_reset();
      idle(1'b0);
      chk("post_reset_empty", 70'(btb_valid), 70'(0));

      // Single update then pop.
      cycle(1'b1, mk(30'h100, 1'b0, 2'd1, 1'b1, 1'b1), 1'b0);
      idle(1'b0);
      chk("single_cntr", 70'(btb_cntr), 70'(2));
      chk("single_valid", 70'(btb_valid), 70'(1));
      idle(1'b1);
      idle(1'b0);
      chk("single_popped", 70'(btb_valid), 70'(0));

      // Back-to-back merge: 3 -> 2 -> 1 in a single entry.
      cycle(1'b1, mk(30'h200, 1'b0, 2'd3, 1'b0, 1'b1), 1'b0);
      cycle(1'b1, mk(30'h200, 1'b0, 2'd3, 1'b0, 1'b1), 1'b0);
      idle(1'b0);
      chk("merge_cntr", 70'(btb_cntr), 70'(1));
      idle(1'b1);
      idle(1'b0);
      chk("merge_one_entry", 70'(btb_valid), 70'(0));

      // Overflow: fifth distinct update dropped, order preserved on drain.
      for (int i = 0; i < 5; i++) cycle(1'b1, mk(30'h300 + 30'(i), 1'b0, 2'd2, 1'b1, 1'b1), 1'b0);
      drain();

      // Full with simultaneous push and pop, new entry lands last.
      for (int i = 0; i < 4; i++) cycle(1'b1, mk(30'h400 + 30'(i), 1'b1, 2'd0, 1'b0, 1'b1), 1'b0);
      cycle(1'b1, mk(30'h4ff, 1'b1, 2'd1, 1'b1, 1'b1), 1'b1);
      drain();

      // Miss installs take the weak counter values.
      cycle(1'b1, mk(30'h500, 1'b0, 2'd0, 1'b1, 1'b0), 1'b0);
      idle(1'b0);
      chk("miss_tkn_cntr", 70'(btb_cntr), 70'(2));
      idle(1'b1);
      cycle(1'b1, mk(30'h501, 1'b0, 2'd3, 1'b0, 1'b0), 1'b0);
      idle(1'b0);
      chk("miss_ntkn_cntr", 70'(btb_cntr), 70'(1));
      drain();

      // Random traffic over a small slot set to exercise merges and drops.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         cycle($urandom_range(0, 9) < 7,
               mk(30'h10 + 30'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) != 0)),
               $urandom_range(0, 9) < 4);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
